// File: rtl/bus_poll_master_if.sv
// ---------------------------------------------------------------------------
// bus_poll_master_if
// Bundles the command, response and peripheral-bus signals of
// bus_poll_master.
//   command : cmd_valid, cmd_ready, cmd_op[1:0], cmd_addr[15:0],
//             cmd_data[7:0], cmd_mask[7:0], cmd_timeout[15:0], abort
//   response: rsp_valid, rsp_ready, rsp_data[7:0], rsp_err
//   bus     : bus_addr[15:0], bus_we, bus_do[7:0], bus_di[7:0]
//   status  : busy
// modport master : the poll master's view (drives the bus and responses)
// modport slave  : the controller/peripheral side
// ---------------------------------------------------------------------------
interface bus_poll_master_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [15:0] cmd_addr;
   logic [7:0]  cmd_data;
   logic [7:0]  cmd_mask;
   logic [15:0] cmd_timeout;
   logic        abort;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [7:0]  rsp_data;
   logic        rsp_err;
   logic [15:0] bus_addr;
   logic        bus_we;
   logic [7:0]  bus_do;
   logic [7:0]  bus_di;
   logic        busy;

   modport master (
      input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask, cmd_timeout,
             abort, rsp_ready, bus_di,
      output cmd_ready, rsp_valid, rsp_data, rsp_err, bus_addr, bus_we,
             bus_do, busy
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask, cmd_timeout,
             abort, rsp_ready, bus_di,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err, bus_addr, bus_we,
             bus_do, busy
   );
endinterface

// File: rtl/bus_poll_master.sv
// ---------------------------------------------------------------------------
// bus_poll_master
// Command-driven initiator for the 8-bit memory-mapped peripheral bus.
// Turns single write, read and poll-until-match commands into bus cycles and
// returns exactly one response per command.
// Parameters:
//   IDLE_ADDR : address presented whenever no access is in progress
//   POLL_GAP  : idle cycles between successive poll reads (0 = back-to-back)
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   pif       : bus_poll_master_if.master (command, response, bus, busy)
// ---------------------------------------------------------------------------
module bus_poll_master #(
   parameter logic [15:0] IDLE_ADDR = 16'hFFFF,
   parameter int unsigned POLL_GAP  = 1
) (
   input logic               clk,
   input logic               rst,
   bus_poll_master_if.master pif
);

   localparam logic [1:0]  OP_WR    = 2'b00;
   localparam logic [1:0]  OP_RD    = 2'b01;
   localparam logic [1:0]  OP_RSV   = 2'b11;
   localparam logic [15:0] GAP_LOAD = 16'(POLL_GAP - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, GAP, RESP} state_t;

   state_t      state, state_n;
   logic [1:0]  op_q, op_n;
   logic [15:0] addr_q, addr_n;
   logic [7:0]  data_q, data_n;
   logic [7:0]  mask_q, mask_n;
   logic [15:0] timeout_q, timeout_n;
   logic [15:0] cnt_q, cnt_n;
   logic [15:0] gap_q, gap_n;
   logic [15:0] bus_addr_q, bus_addr_n;
   logic        bus_we_q, bus_we_n;
   logic [7:0]  bus_do_q, bus_do_n;
   logic [7:0]  rsp_data_q, rsp_data_n;
   logic        rsp_err_q, rsp_err_n;

   logic        match;
   logic [15:0] cnt_inc;
   logic        timed_out;

   // Only the masked bits take part in the compare; mask 0 always matches.
   assign match     = ((pif.bus_di ^ data_q) & mask_q) == 8'h00;
   assign cnt_inc   = cnt_q + 16'd1;
   // A zero timeout means unlimited: the counter simply wraps.
   assign timed_out = (timeout_q != 16'd0) && (cnt_inc == timeout_q);

   assign pif.cmd_ready = (state == IDLE);
   assign pif.busy      = (state != IDLE);
   assign pif.rsp_valid = (state == RESP);
   assign pif.rsp_data  = rsp_data_q;
   assign pif.rsp_err   = rsp_err_q;
   assign pif.bus_addr  = bus_addr_q;
   assign pif.bus_we    = bus_we_q;
   assign pif.bus_do    = bus_do_q;

   // Bus outputs are registered from the next state, so the target address
   // appears only during ACCESS and falls back to IDLE_ADDR otherwise
   // (reads of some peripherals have side effects).
   always_comb begin
      state_n    = state;
      op_n       = op_q;
      addr_n     = addr_q;
      data_n     = data_q;
      mask_n     = mask_q;
      timeout_n  = timeout_q;
      cnt_n      = cnt_q;
      gap_n      = gap_q;
      bus_addr_n = IDLE_ADDR;
      bus_we_n   = 1'b0;
      bus_do_n   = bus_do_q;
      rsp_data_n = rsp_data_q;
      rsp_err_n  = rsp_err_q;

      case (state)
         IDLE: begin
            if (pif.cmd_valid) begin
               op_n      = pif.cmd_op;
               addr_n    = pif.cmd_addr;
               data_n    = pif.cmd_data;
               mask_n    = pif.cmd_mask;
               timeout_n = pif.cmd_timeout;
               cnt_n     = 16'd0;
               rsp_err_n = 1'b0;
               if (pif.cmd_op == OP_RSV) begin
                  // Reserved op: answer immediately without touching the bus.
                  state_n    = RESP;
                  rsp_err_n  = 1'b1;
                  rsp_data_n = 8'h00;
               end else begin
                  state_n    = ACCESS;
                  bus_addr_n = pif.cmd_addr;
                  bus_we_n   = (pif.cmd_op == OP_WR);
                  bus_do_n   = pif.cmd_data;
               end
            end
         end

         ACCESS: begin
            case (op_q)
               OP_WR: begin
                  rsp_data_n = data_q;
                  state_n    = RESP;
               end
               OP_RD: begin
                  rsp_data_n = pif.bus_di;
                  state_n    = RESP;
               end
               default: begin
                  // Poll: the read always completes; a match on this read
                  // wins over an abort arriving in the same cycle.
                  rsp_data_n = pif.bus_di;
                  cnt_n      = cnt_inc;
                  if (match) begin
                     state_n   = RESP;
                     rsp_err_n = 1'b0;
                  end else if (pif.abort || timed_out) begin
                     state_n   = RESP;
                     rsp_err_n = 1'b1;
                  end else if (POLL_GAP == 0) begin
                     state_n    = ACCESS;
                     bus_addr_n = addr_q;
                  end else begin
                     state_n = GAP;
                     gap_n   = GAP_LOAD;
                  end
               end
            endcase
         end

         GAP: begin
            if (pif.abort) begin
               state_n   = RESP;
               rsp_err_n = 1'b1;
            end else if (gap_q == 16'd0) begin
               state_n    = ACCESS;
               bus_addr_n = addr_q;
            end else begin
               gap_n = gap_q - 16'd1;
            end
         end

         RESP: begin
            if (pif.rsp_ready) state_n = IDLE;
         end

         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         bus_addr_q <= IDLE_ADDR;
         bus_we_q   <= 1'b0;
         bus_do_q   <= 8'h00;
         rsp_data_q <= 8'h00;
         rsp_err_q  <= 1'b0;
      end else begin
         state      <= state_n;
         bus_addr_q <= bus_addr_n;
         bus_we_q   <= bus_we_n;
         bus_do_q   <= bus_do_n;
         rsp_data_q <= rsp_data_n;
         rsp_err_q  <= rsp_err_n;
      end
   end

   // Command context is always loaded on accept before use, so it needs no reset.
   always_ff @(posedge clk) begin
      op_q      <= op_n;
      addr_q    <= addr_n;
      data_q    <= data_n;
      mask_q    <= mask_n;
      timeout_q <= timeout_n;
      cnt_q     <= cnt_n;
      gap_q     <= gap_n;
   end

endmodule
